fft_sdf_ctrl: RTL and testbench

FFT_SDF_CTRL -- requirements
Module: fft_sdf_ctrl

---
 rtl/fft_pkg.sv | 16 +
 rtl/fft_sdf_ctrl_if.sv | 30 +++
 rtl/sel_delay_line.sv | 34 +++
 rtl/fft_sdf_ctrl.sv | 147 ++++++++++++++
 tb/tb_fft_sdf_ctrl.sv | 129 ++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the single-delay-feedback FFT controller.
//   DEF_LOG2N / DEF_N : default transform size (log2 and points)
//   state_t           : controller state encoding
package fft_pkg;

    localparam int DEF_LOG2N = 3;
    localparam int DEF_N     = 1 << DEF_LOG2N;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

endpackage

// File: rtl/fft_sdf_ctrl_if.sv
// Handshake/status bundle between the SDF controller and its environment.
//   start, in_valid       : frame arm and sample-present strobes (to controller)
//   sel[LOG2N-1:0]        : per-stage mux/demux select (bit s -> stage s)
//   out_valid, out_first  : result strobe and first-result-of-frame marker
//   out_idx[CW-1:0]       : frequency bin of the current result
//   busy, err             : not-idle flag, mid-frame gap pulse
// master = environment side, slave = controller side.
interface fft_sdf_ctrl_if #(
    parameter int LOG2N = 3,
    parameter int CW    = LOG2N
);
    logic             start;
    logic             in_valid;
    logic [LOG2N-1:0] sel;
    logic             out_valid;
    logic             out_first;
    logic [CW-1:0]    out_idx;
    logic             busy;
    logic             err;

    modport master (
        output start, in_valid,
        input  sel, out_valid, out_first, out_idx, busy, err
    );

    modport slave (
        input  start, in_valid,
        output sel, out_valid, out_first, out_idx, busy, err
    );
endinterface

// File: rtl/sel_delay_line.sv
// Delays one bit of the sample counter by DEPTH advance steps to form a
// stage select. Shifts only while the pipeline advances; flush empties it.
//   clk, clear : clock, asynchronous active-low reset
//   en         : pipeline advances this cycle
//   flush      : synchronous clear when the frame is dropped / finished
//   d, q       : counter bit in, delayed select out
// DEPTH must be at least 1.
module sel_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic clear,
    input  logic en,
    input  logic flush,
    input  logic d,
    output logic q
);
    logic [DEPTH-1:0] tap_p;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            tap_p <= '0;
        end else if (flush) begin
            tap_p <= '0;
        end else if (en) begin
            tap_p[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                tap_p[i] <= tap_p[i-1];
            end
        end
    end

    assign q = tap_p[DEPTH-1];
endmodule

// File: rtl/fft_sdf_ctrl.sv
// Control for a radix-2 single-delay-feedback FFT of N = 2^LOG2N points.
// Tracks the input sample counter, derives the per-stage selects from
// delayed counter bits, and produces the output strobe, first-of-frame flag
// and bit-reversed output bin. Intended for LOG2N >= 2.
//   clk   : clock, rising edge
//   clear : asynchronous active-low reset
//   bus   : fft_sdf_ctrl_if slave (start, in_valid in; sel, out_valid,
//           out_first, out_idx, busy, err out)
module fft_sdf_ctrl
    import fft_pkg::*;
#(
    parameter int LOG2N = DEF_LOG2N,
    parameter int CW    = LOG2N
) (
    input logic           clk,
    input logic           clear,
    fft_sdf_ctrl_if.slave bus
);
    localparam int N = 1 << LOG2N;
    // Counter value of the last FILL sample; the next cycle streams.
    localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 2);

    state_t           state;
    state_t           state_nxt;
    logic             armed;
    logic             armed_nxt;
    logic [LOG2N-1:0] cnt;
    logic [LOG2N-1:0] ocnt;
    logic             adv;
    logic             flush;
    logic             err_c;
    logic             out_vld;
    logic [LOG2N-1:0] sel_p;
    logic [LOG2N-1:0] idx_rev;

    function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state <= ST_IDLE;
            armed <= 1'b0;
            cnt   <= '0;
            ocnt  <= '0;
        end else begin
            state <= state_nxt;
            armed <= armed_nxt;
            if (flush) begin
                cnt <= '0;
            end else if (adv) begin
                cnt <= cnt + 1'b1;
            end
            if (flush) begin
                ocnt <= '0;
            end else if (out_vld) begin
                ocnt <= ocnt + 1'b1;
            end
        end
    end

    // The boundary gap cycle in STREAM already counts as the first drain
    // step, so DRAIN proper ends when the counter reaches N-2.
    always_comb begin
        state_nxt = state;
        armed_nxt = armed;
        adv       = 1'b0;
        flush     = 1'b0;
        err_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.in_valid && (bus.start || armed)) begin
                    adv       = 1'b1;
                    armed_nxt = 1'b0;
                    state_nxt = ST_FILL;
                end else if (bus.start) begin
                    armed_nxt = 1'b1;
                end
            end
            ST_FILL: begin
                if (bus.in_valid) begin
                    adv = 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_nxt = ST_STREAM;
                    end
                end else begin
                    err_c     = 1'b1;
                    flush     = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (bus.in_valid) begin
                    adv = 1'b1;
                end else if (cnt == '0) begin
                    adv       = 1'b1;
                    state_nxt = ST_DRAIN;
                end else begin
                    err_c     = 1'b1;
                    flush     = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (cnt == CNT_LAST) begin
                    flush     = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    adv = 1'b1;
                end
            end
            default: begin
                flush     = 1'b1;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Stage 0 has no delay; stage s sees the counter N - 2^(LOG2N-s) steps late.
    assign sel_p[0] = cnt[LOG2N-1];

    for (genvar s = 1; s < LOG2N; s++) begin : g_stage
        sel_delay_line #(
            .DEPTH(N - (1 << (LOG2N - s)))
        ) u_sel_dly (
            .clk  (clk),
            .clear(clear),
            .en   (adv),
            .flush(flush),
            .d    (cnt[LOG2N-1-s]),
            .q    (sel_p[s])
        );
    end

    assign out_vld       = (state == ST_STREAM) || (state == ST_DRAIN);
    assign idx_rev       = bit_rev(ocnt);
    assign bus.sel       = sel_p;
    assign bus.out_valid = out_vld;
    assign bus.out_first = out_vld && (ocnt == '0);
    assign bus.out_idx   = CW'(idx_rev);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.err       = err_c;
endmodule

// File: tb/tb_fft_sdf_ctrl.sv
// Directed bench for fft_sdf_ctrl at LOG2N=3 (N=8). Inputs change on the
// falling edge; outputs are sampled 1 time unit later. Cycle k of a scenario
// is the cycle whose inputs are the k-th drive of that scenario.
module tb_fft_sdf_ctrl;
    import fft_pkg::*;

    localparam int LOG2N = DEF_LOG2N;
    localparam int N     = DEF_N;
    localparam int CW    = LOG2N;

    logic clk = 1'b0;
    logic clear;

    always #5 clk = ~clk;

    fft_sdf_ctrl_if #(.LOG2N(LOG2N), .CW(CW)) bus ();

    fft_sdf_ctrl #(.LOG2N(LOG2N), .CW(CW)) dut (
        .clk  (clk),
        .clear(clear),
        .bus  (bus.slave)
    );

    int n_total = 0;
    int n_bad   = 0;

    int idx_tbl [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    bit sel0_tbl[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    bit sel1_tbl[4] = '{0, 0, 1, 1};
    bit sel2_tbl[2] = '{0, 1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic drive(input bit s, input bit v);
        @(negedge clk);
        bus.start    = s;
        bus.in_valid = v;
        #1;
    endtask

    // t: timeline position of this cycle within the frame sequence
    // (0 = first accepted sample), or -1 when the controller sits idle.
    task automatic check_cycle(input string grp, input int k, input int t,
                               input bit ov, input bit bsy, input bit er);
        logic [2:0] es;
        bit         ef;
        int         eidx;
        es = 3'b000;
        if (t >= 0) es[0] = sel0_tbl[t % 8];
        if (t >= 4) es[1] = sel1_tbl[(t - 4) % 4];
        if (t >= 6) es[2] = sel2_tbl[(t - 6) % 2];
        ef   = ov && (((t - 7) % 8) == 0);
        eidx = ov ? idx_tbl[(t - 7) % 8] : 0;
        chk($sformatf("%s c%0d sel", grp, k),       32'(bus.sel),       32'(es));
        chk($sformatf("%s c%0d out_valid", grp, k), 32'(bus.out_valid), 32'(ov));
        chk($sformatf("%s c%0d out_first", grp, k), 32'(bus.out_first), 32'(ef));
        chk($sformatf("%s c%0d out_idx", grp, k),   32'(bus.out_idx),   32'(eidx));
        chk($sformatf("%s c%0d busy", grp, k),      32'(bus.busy),      32'(bsy));
        chk($sformatf("%s c%0d err", grp, k),       32'(bus.err),       32'(er));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        clear        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_cycle("reset", 0, -1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        clear = 1'b1;

        // Three back-to-back frames, start repeated on frame boundaries,
        // then drain with a start+in_valid poke, then unarmed in_valid in IDLE.
        for (int k = 0; k <= 32; k++) begin
            drive((k == 0) || (k == 8) || (k == 16) || (k == 26),
                  (k < 24) || (k == 26) || (k >= 31));
            check_cycle("frames3", k, (k <= 30) ? k : -1,
                        (k >= 7) && (k <= 30), (k >= 1) && (k <= 30), 1'b0);
        end

        // Gap after sample 5: err pulse, frame dropped.
        for (int k = 0; k <= 10; k++) begin
            drive(k == 0, k <= 5);
            check_cycle("gap", k, (k <= 6) ? k : -1,
                        1'b0, (k >= 1) && (k <= 6), k == 6);
        end

        // start held 5 cycles without data, then one frame and drain.
        for (int k = 0; k <= 21; k++) begin
            drive(k < 5, (k >= 5) && (k <= 12));
            check_cycle("armed", k, ((k >= 5) && (k <= 19)) ? k - 5 : -1,
                        (k >= 12) && (k <= 19), (k >= 6) && (k <= 19), 1'b0);
        end

        // Reset while streaming.
        for (int k = 0; k <= 9; k++) begin
            drive(k == 0, 1'b1);
            check_cycle("prerst", k, k, k >= 7, k >= 1, 1'b0);
        end
        @(negedge clk);
        clear = 1'b0;
        #1;
        check_cycle("asyncrst", 0, -1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_cycle("asyncrst", 1, -1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        clear = 1'b1;
        for (int k = 0; k <= 2; k++) begin
            drive(1'b0, 1'b1);
            check_cycle("postrst", k, -1, 1'b0, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
